// File: rtl/fetch_seq_if.sv
// Bundle between fetch_seq, the memory read port, opcode decoder and execute stage.
// Holds only wires; timing is defined by the sequencer that drives the master side.
// master = sequencer, slave = memory / decoder / execute environment.
interface fetch_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [2:0]        mode;
  logic [DATA_W-1:0] x_idx;
  logic [DATA_W-1:0] y_idx;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] oper;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] pc;
  logic              exec_valid;
  logic              exec_ready;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;

  modport master (
    output mem_addr, mem_rd, ir, oper, eff_addr, pc, exec_valid,
    input  mem_rdata, mem_ready, mode, x_idx, y_idx, exec_ready, pc_load, pc_target
  );

  modport slave (
    input  mem_addr, mem_rd, ir, oper, eff_addr, pc, exec_valid,
    output mem_rdata, mem_ready, mode, x_idx, y_idx, exec_ready, pc_load, pc_target
  );
endinterface

// File: rtl/fetch_seq.sv
// 6502 fetch/operand sequencer: reset vector, opcode fetch, operand collection, effective address.
// Latency FETCH->accept: IMP 3, IMM/ZP/ZPX 4, ABS/ABSX/ABSY 5, IND 7 cycles with no wait states.
// Reads hold address/request until mem_ready; ISSUE holds the bundle until exec_ready.
module fetch_seq #(
  parameter int                ADDR_W       = 16,
  parameter int                DATA_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC    = 16'hFFFC,
  parameter bit                IND_PAGE_BUG = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  fetch_seq_if.master bus
);

  // Address is assumed to be exactly two data bytes wide (low byte, high byte).
  localparam int                HI_W        = ADDR_W - DATA_W;
  localparam logic [ADDR_W-1:0] VEC_HI_ADDR = RESET_VEC + {{(ADDR_W-1){1'b0}}, 1'b1};

  localparam logic [2:0] M_IMP  = 3'd0;
  localparam logic [2:0] M_IMM  = 3'd1;
  localparam logic [2:0] M_ZP   = 3'd2;
  localparam logic [2:0] M_ZPX  = 3'd3;
  localparam logic [2:0] M_ABSY = 3'd6;
  localparam logic [2:0] M_IND  = 3'd7;

  typedef enum logic [3:0] {
    S_RESET, S_VEC_LO, S_VEC_HI, S_FETCH, S_DECODE,
    S_OP_LO, S_OP_HI, S_IND_LO, S_IND_HI, S_ISSUE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] mem_addr_q;   // also serves as the indirect pointer in IND_LO/IND_HI
  logic [ADDR_W-1:0] eff_addr_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] oper_q;
  logic [2:0]        mode_q;
  logic              mem_rd_q;
  logic              exec_valid_q;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] abs_base;
  logic [DATA_W-1:0] idx_val;
  logic [ADDR_W-1:0] idx_sum;
  logic [DATA_W-1:0] zpx_lo;
  logic [DATA_W-1:0] ptr_lo_inc;
  logic [ADDR_W-1:0] ptr_next;

  // Address arithmetic; all sums wrap modulo the operand width (carry out discarded).
  always_comb begin
    pc_inc     = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    abs_base   = {bus.mem_rdata[HI_W-1:0], oper_q};
    idx_val    = (mode_q == M_ABSY) ? bus.y_idx : bus.x_idx;
    idx_sum    = abs_base + {{HI_W{1'b0}}, idx_val};
    zpx_lo     = bus.mem_rdata + bus.x_idx;
    ptr_lo_inc = mem_addr_q[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, 1'b1};
    if (IND_PAGE_BUG) begin
      ptr_next = {mem_addr_q[ADDR_W-1:DATA_W], ptr_lo_inc};
    end else begin
      ptr_next = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Sequencer: state, memory request and the instruction bundle all registered here.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_RESET;
      pc_q         <= '0;
      mem_addr_q   <= '0;
      eff_addr_q   <= '0;
      ir_q         <= '0;
      oper_q       <= '0;
      mode_q       <= M_IMP;
      mem_rd_q     <= 1'b0;
      exec_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          state_q    <= S_VEC_LO;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= RESET_VEC;
        end
        S_VEC_LO: if (bus.mem_ready) begin
          pc_q[DATA_W-1:0] <= bus.mem_rdata;
          mem_addr_q       <= VEC_HI_ADDR;
          state_q          <= S_VEC_HI;
        end
        S_VEC_HI: if (bus.mem_ready) begin
          pc_q       <= {bus.mem_rdata[HI_W-1:0], pc_q[DATA_W-1:0]};
          mem_addr_q <= {bus.mem_rdata[HI_W-1:0], pc_q[DATA_W-1:0]};
          state_q    <= S_FETCH;
        end
        S_FETCH: if (bus.mem_ready) begin
          ir_q     <= bus.mem_rdata;
          pc_q     <= pc_inc;
          mem_rd_q <= 1'b0;
          state_q  <= S_DECODE;
        end
        S_DECODE: begin
          mode_q <= bus.mode;
          if (bus.mode == M_IMP) begin
            oper_q       <= '0;
            eff_addr_q   <= '0;
            exec_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end else begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= pc_q;
            state_q    <= S_OP_LO;
          end
        end
        S_OP_LO: if (bus.mem_ready) begin
          oper_q <= bus.mem_rdata;
          pc_q   <= pc_inc;
          if (mode_q == M_IMM || mode_q == M_ZP || mode_q == M_ZPX) begin
            if (mode_q == M_IMM) begin
              eff_addr_q <= '0;
            end else if (mode_q == M_ZP) begin
              eff_addr_q <= {{HI_W{1'b0}}, bus.mem_rdata};
            end else begin
              eff_addr_q <= {{HI_W{1'b0}}, zpx_lo};
            end
            mem_rd_q     <= 1'b0;
            exec_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end else begin
            mem_addr_q <= pc_inc;
            state_q    <= S_OP_HI;
          end
        end
        S_OP_HI: if (bus.mem_ready) begin
          pc_q <= pc_inc;
          if (mode_q == M_IND) begin
            mem_addr_q <= abs_base;
            state_q    <= S_IND_LO;
          end else begin
            eff_addr_q   <= (mode_q == 3'd4) ? abs_base : idx_sum;
            mem_rd_q     <= 1'b0;
            exec_valid_q <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_IND_LO: if (bus.mem_ready) begin
          eff_addr_q[DATA_W-1:0] <= bus.mem_rdata;
          mem_addr_q             <= ptr_next;
          state_q                <= S_IND_HI;
        end
        S_IND_HI: if (bus.mem_ready) begin
          eff_addr_q[ADDR_W-1:DATA_W] <= bus.mem_rdata[HI_W-1:0];
          mem_rd_q                    <= 1'b0;
          exec_valid_q                <= 1'b1;
          state_q                     <= S_ISSUE;
        end
        S_ISSUE: if (bus.exec_ready) begin
          // Redirect is honoured only on the accepting cycle.
          exec_valid_q <= 1'b0;
          mem_rd_q     <= 1'b1;
          if (bus.pc_load) begin
            pc_q       <= bus.pc_target;
            mem_addr_q <= bus.pc_target;
          end else begin
            mem_addr_q <= pc_q;
          end
          state_q <= S_FETCH;
        end
        default: begin
          state_q      <= S_RESET;
          mem_rd_q     <= 1'b0;
          exec_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.ir         = ir_q;
  assign bus.oper       = oper_q;
  assign bus.eff_addr   = eff_addr_q;
  assign bus.pc         = pc_q;
  assign bus.exec_valid = exec_valid_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: two instances (indirect page wrap on and off) share one memory and stimulus.
// Vector table and hand sequences for latency/stall/reset, then a random stream vs a reference model.
module tb_fetch_seq;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fetch_seq_if #(.ADDR_W(16), .DATA_W(8)) bus0 ();
  fetch_seq_if #(.ADDR_W(16), .DATA_W(8)) bus1 ();

  fetch_seq #(.ADDR_W(16), .DATA_W(8), .RESET_VEC(16'hFFFC), .IND_PAGE_BUG(1'b1))
    u_dut_bug (.clk(clk), .resetn(resetn), .bus(bus0));
  fetch_seq #(.ADDR_W(16), .DATA_W(8), .RESET_VEC(16'hFFFC), .IND_PAGE_BUG(1'b0))
    u_dut_flat (.clk(clk), .resetn(resetn), .bus(bus1));

  logic [7:0]  mem      [0:65535];
  logic [2:0]  mode_tab [0:255];
  logic        mem_ready, exec_ready, pc_load;
  logic [15:0] pc_target;
  logic [7:0]  x_idx, y_idx;

  assign bus0.mem_rdata  = mem[bus0.mem_addr];
  assign bus1.mem_rdata  = mem[bus1.mem_addr];
  assign bus0.mode       = mode_tab[bus0.ir];
  assign bus1.mode       = mode_tab[bus1.ir];
  assign bus0.mem_ready  = mem_ready;
  assign bus1.mem_ready  = mem_ready;
  assign bus0.exec_ready = exec_ready;
  assign bus1.exec_ready = exec_ready;
  assign bus0.pc_load    = pc_load;
  assign bus1.pc_load    = pc_load;
  assign bus0.pc_target  = pc_target;
  assign bus1.pc_target  = pc_target;
  assign bus0.x_idx      = x_idx;
  assign bus1.x_idx      = x_idx;
  assign bus0.y_idx      = y_idx;
  assign bus1.y_idx      = y_idx;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  op, b1, b2, x, y, e_oper;
    logic [15:0] e_eff1, e_eff0;
    int          len, lat;
  } vec_t;
  vec_t vt [0:8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] add16(input logic [15:0] a, input int b);
    return 16'(int'(a) + b);
  endfunction

  task automatic place(input logic [15:0] a, input logic [7:0] op, b1, b2);
    mem[a]           = op;
    mem[add16(a, 1)] = b1;
    mem[add16(a, 2)] = b2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd"},    32'(bus0.mem_rd), 0);
    chk({tag, "_addr"},  32'(bus0.mem_addr), 0);
    chk({tag, "_ir"},    32'(bus0.ir), 0);
    chk({tag, "_oper"},  32'(bus0.oper), 0);
    chk({tag, "_eff"},   32'(bus0.eff_addr), 0);
    chk({tag, "_pc"},    32'(bus0.pc), 0);
    chk({tag, "_valid"}, 32'(bus0.exec_valid), 0);
    chk({tag, "_valid1"}, 32'(bus1.exec_valid), 0);
  endtask

  // From a FETCH cycle with no wait states: count cycles to ISSUE, check bundle, accept.
  task automatic run_fixed(input string nm, input bit load, input logic [15:0] tgt,
                           input logic [7:0] e_ir, e_oper, input logic [15:0] e_eff1, e_eff0,
                           input logic [15:0] e_pc, input int e_lat);
    int n;
    n = 1;
    mem_ready = 1'b1; exec_ready = 1'b1; pc_load = load; pc_target = tgt;
    while (!bus0.exec_valid && n < 40) begin
      step();
      n++;
    end
    chk({nm, "_lat"},   n, e_lat);
    chk({nm, "_ir"},    32'(bus0.ir), 32'(e_ir));
    chk({nm, "_oper"},  32'(bus0.oper), 32'(e_oper));
    chk({nm, "_eff"},   32'(bus0.eff_addr), 32'(e_eff1));
    chk({nm, "_eff_flat"}, 32'(bus1.eff_addr), 32'(e_eff0));
    chk({nm, "_pc"},    32'(bus0.pc), 32'(e_pc));
    step();
    pc_load = 1'b0;
    chk({nm, "_drop"},  32'(bus0.exec_valid), 0);
    chk({nm, "_next"},  32'(bus0.mem_addr), 32'(load ? tgt : e_pc));
  endtask

  // Reference: bundle from addressing-mode rules with plain arithmetic on the memory image.
  task automatic model(input logic [7:0] op, b1, b2, x, y, output logic [7:0] e_oper,
                       output logic [15:0] e1, e0, output int len);
    int base, ptr;
    logic [7:0] lo, hi_bug, hi_flat;
    base = int'(b2) * 256 + int'(b1);
    e_oper = b1; e1 = 16'h0; len = 2;
    case (mode_tab[op])
      3'd0: begin e_oper = 8'h00; len = 1; end
      3'd1: ;
      3'd2: e1 = {8'h00, b1};
      3'd3: e1 = 16'((int'(b1) + int'(x)) % 256);
      3'd4: begin len = 3; e1 = 16'(base); end
      3'd5: begin len = 3; e1 = 16'((base + int'(x)) % 65536); end
      3'd6: begin len = 3; e1 = 16'((base + int'(y)) % 65536); end
      default: begin
        len = 3;
        ptr = base;
        lo      = mem[16'(ptr)];
        hi_bug  = mem[16'((ptr / 256) * 256 + (ptr + 1) % 256)];
        hi_flat = mem[16'((ptr + 1) % 65536)];
        e1 = {hi_bug, lo};
      end
    endcase
    e0 = e1;
    if (mode_tab[op] == 3'd7) e0 = {hi_flat, lo};
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pc_m, a2, a3;
    logic [7:0]  op, b1, b2, e_oper;
    logic [15:0] e1, e0;
    int          len, got;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 256; i++) mode_tab[i] = 3'(i);
    mode_tab[8'hA9] = 3'd1; mode_tab[8'hEA] = 3'd0; mode_tab[8'hA5] = 3'd2;
    mode_tab[8'hB5] = 3'd3; mode_tab[8'hAD] = 3'd4; mode_tab[8'hBD] = 3'd5;
    mode_tab[8'hB9] = 3'd6; mode_tab[8'h6C] = 3'd7;

    //          op     b1     b2     x      y      oper   eff(bug)  eff(flat) len lat
    vt[0] = '{8'hA9, 8'h42, 8'h00, 8'h00, 8'h00, 8'h42, 16'h0000, 16'h0000, 2, 4};
    vt[1] = '{8'hEA, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 1, 3};
    vt[2] = '{8'hA5, 8'h80, 8'h00, 8'h00, 8'h00, 8'h80, 16'h0080, 16'h0080, 2, 4};
    vt[3] = '{8'hB5, 8'hF0, 8'h00, 8'h20, 8'h00, 8'hF0, 16'h0010, 16'h0010, 2, 4};
    vt[4] = '{8'hAD, 8'h34, 8'h12, 8'h00, 8'h00, 8'h34, 16'h1234, 16'h1234, 3, 5};
    vt[5] = '{8'hBD, 8'hF0, 8'hFF, 8'h20, 8'h00, 8'hF0, 16'h0010, 16'h0010, 3, 5};
    vt[6] = '{8'hB9, 8'h00, 8'h20, 8'h00, 8'hFF, 8'h00, 16'h20FF, 16'h20FF, 3, 5};
    vt[7] = '{8'h6C, 8'hFF, 8'h10, 8'h00, 8'h00, 8'hFF, 16'h1234, 16'h5634, 3, 7};
    vt[8] = '{8'h6C, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 16'hABCD, 16'hABCD, 3, 7};

    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
    mem[16'h10FF] = 8'h34; mem[16'h1000] = 8'h12; mem[16'h1100] = 8'h56;
    mem[16'h3000] = 8'hCD; mem[16'h3001] = 8'hAB;

    // Reset and vector fetch
    resetn = 1'b0; mem_ready = 1'b1; exec_ready = 1'b1; pc_load = 1'b0;
    pc_target = 16'h0; x_idx = 8'h0; y_idx = 8'h0;
    repeat (3) step();
    chk_reset("rst");
    resetn = 1'b1;
    step(); chk("vec_lo_addr", 32'(bus0.mem_addr), 32'hFFFC); chk("vec_lo_rd", 32'(bus0.mem_rd), 1);
    step(); chk("vec_hi_addr", 32'(bus0.mem_addr), 32'hFFFD);
    step(); chk("fetch0_addr", 32'(bus0.mem_addr), 32'hC000); chk("fetch0_pc", 32'(bus0.pc), 32'hC000);

    // Vector table from C000
    pc_m = 16'hC000;
    for (int i = 0; i < 9; i++) begin
      place(pc_m, vt[i].op, vt[i].b1, vt[i].b2);
      x_idx = vt[i].x; y_idx = vt[i].y;
      run_fixed($sformatf("vec%0d", i), 1'b0, 16'h0, vt[i].op, vt[i].e_oper,
                vt[i].e_eff1, vt[i].e_eff0, add16(pc_m, vt[i].len), vt[i].lat);
      pc_m = add16(pc_m, vt[i].len);
    end
    chk("table_end_pc", 32'(bus0.pc), 32'hC016);

    // Stall in OP_HI, stall in ISSUE, redirect on accept
    place(pc_m, 8'hAD, 8'h78, 8'h56);
    a2 = add16(pc_m, 2); a3 = add16(pc_m, 3);
    mem_ready = 1'b1; exec_ready = 1'b0; pc_load = 1'b0;
    repeat (3) step();
    chk("stall_ophi_addr", 32'(bus0.mem_addr), 32'(a2));
    mem_ready = 1'b0; pc_load = 1'b1; pc_target = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_mem_addr", 32'(bus0.mem_addr), 32'(a2));
      chk("stall_mem_rd",   32'(bus0.mem_rd), 1);
      chk("stall_mem_pc",   32'(bus0.pc), 32'(a2));
      chk("stall_mem_valid", 32'(bus0.exec_valid), 0);
    end
    mem_ready = 1'b1;
    step();
    chk("stall_issue_valid", 32'(bus0.exec_valid), 1);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stall_ex_valid", 32'(bus0.exec_valid), 1);
      chk("stall_ex_eff",   32'(bus0.eff_addr), 32'h5678);
      chk("stall_ex_ir",    32'(bus0.ir), 32'hAD);
      chk("stall_ex_oper",  32'(bus0.oper), 32'h78);
      chk("stall_ex_pc",    32'(bus0.pc), 32'(a3));
    end
    exec_ready = 1'b1; pc_target = 16'h8000;
    step();
    pc_load = 1'b0;
    chk("redir_valid", 32'(bus0.exec_valid), 0);
    chk("redir_addr",  32'(bus0.mem_addr), 32'h8000);
    chk("redir_rd",    32'(bus0.mem_rd), 1);
    chk("redir_pc",    32'(bus0.pc), 32'h8000);
    pc_m = 16'h8000;

    // Random stream with wait states, backpressure and spurious redirects
    for (int t = 0; t < 300; t++) begin
      op = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
      place(pc_m, op, b1, b2);
      x_idx = 8'($urandom); y_idx = 8'($urandom);
      model(op, b1, b2, x_idx, y_idx, e_oper, e1, e0, len);
      got = 0;
      for (int c = 0; c < 300 && got == 0; c++) begin
        mem_ready  = ($urandom % 4) != 0;
        exec_ready = ($urandom % 3) != 0;
        pc_load    = ($urandom % 8) == 0;
        pc_target  = 16'($urandom);
        if (bus0.exec_valid && exec_ready) begin
          got = 1;
          chk("rnd_ir",       32'(bus0.ir), 32'(op));
          chk("rnd_oper",     32'(bus0.oper), 32'(e_oper));
          chk("rnd_eff",      32'(bus0.eff_addr), 32'(e1));
          chk("rnd_eff_flat", 32'(bus1.eff_addr), 32'(e0));
          chk("rnd_pc",       32'(bus0.pc), 32'(add16(pc_m, len)));
          chk("rnd_valid1",   32'(bus1.exec_valid), 1);
          pc_m = pc_load ? pc_target : add16(pc_m, len);
        end
        step();
      end
      if (got == 0) chk("rnd_timeout", 0, 1);
    end
    pc_load = 1'b0; mem_ready = 1'b1; exec_ready = 1'b1;

    // Reset while the indirect pointer is being read
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
    place(pc_m, 8'h6C, 8'h00, 8'h30);
    repeat (4) step();
    chk("mid_indlo_addr", 32'(bus0.mem_addr), 32'h3000);
    resetn = 1'b0;
    step();
    chk_reset("midrst");
    resetn = 1'b1;
    step(); chk("re_vec_lo", 32'(bus0.mem_addr), 32'hFFFC);
    step(); chk("re_vec_hi", 32'(bus0.mem_addr), 32'hFFFD);
    step(); chk("re_fetch",  32'(bus0.mem_addr), 32'hC000);

    // PC wrap: redirect to FFFF, fetch there, pc becomes 0000
    mem[16'hC000] = 8'hEA;
    mem[16'hFFFF] = 8'hEA;
    run_fixed("wrap_jump", 1'b1, 16'hFFFF, 8'hEA, 8'h00, 16'h0, 16'h0, 16'hC001, 3);
    run_fixed("wrap_ffff", 1'b0, 16'h0, 8'hEA, 8'h00, 16'h0, 16'h0, 16'h0000, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Parametrised instruction fetch and operand-address sequencer for the 6502 core; successor to the single-mode fetch/decode FSM.
- Runs the reset-vector sequence, fetches opcodes, and collects 0–2 operand bytes per the addressing mode supplied by the external opcode decoder.
- Forms the effective address (zero page, indexed, absolute, indirect) and hands a complete instruction to the execute stage over a valid/ready handshake.
- Memory reads use a ready-qualified request, so wait states are supported.

Parameters:
ADDR_W, 16, address and PC width
DATA_W, 8, memory data, opcode and operand width
RESET_VEC, 16'hFFFC, address of reset vector low byte (high byte at RESET_VEC+1)
IND_PAGE_BUG, 1, 1 = indirect high-pointer byte wraps within page (NMOS behaviour); 0 = full ADDR_W carry

Ports:
clk  in  1  clock
resetn  in  1  reset
mem_addr  out  ADDR_W  read address
mem_rd  out  1  read request, held until accepted
mem_rdata  in  DATA_W  read data, valid when mem_rd && mem_ready
mem_ready  in  1  read completes this cycle
mode  in  3  addressing mode, combinational function of ir: 0 IMP, 1 IMM, 2 ZP, 3 ZPX, 4 ABS, 5 ABSX, 6 ABSY, 7 IND
x_idx  in  DATA_W  X register
y_idx  in  DATA_W  Y register
ir  out  DATA_W  current opcode
oper  out  DATA_W  immediate or low operand byte
eff_addr  out  ADDR_W  effective address
pc  out  ADDR_W  address of next unfetched byte
exec_valid  out  1  instruction bundle valid
exec_ready  in  1  execute accepts bundle
pc_load  in  1  redirect, sampled only on accept
pc_target  in  ADDR_W  redirect target

Behaviour:
- Reset: resetn is synchronous, active-low; clock is clk. Reset is sampled every cycle and overrides all activity, including mid-read and mid-handshake.
- Values while in reset: state RESET; mem_rd=0; mem_addr=0; ir=0; oper=0; eff_addr=0; pc=0; exec_valid=0.
- States: RESET, VEC_LO, VEC_HI, FETCH, DECODE, OP_LO, OP_HI, IND_LO, IND_HI, ISSUE.
- Memory rule: a "read" is a state driving mem_rd=1 with a stable mem_addr. The state advances only on the cycle with mem_ready=1, and data is captured that cycle. With mem_ready=0 the state, address and request all hold.
- RESET -> VEC_LO (1 cycle, no read).
- VEC_LO reads RESET_VEC into pc[7:0]; VEC_HI reads RESET_VEC+1 into pc[15:8]; then -> FETCH.
- FETCH reads pc into ir; pc<=pc+1; -> DECODE.
- DECODE: 1 cycle, no read; mode is sampled here.
  - IMP -> ISSUE with oper=0, eff_addr=0.
  - Every other mode -> OP_LO.
- OP_LO reads pc into oper; pc<=pc+1.
  - IMM: eff_addr=0 -> ISSUE.
  - ZP: eff_addr={0,byte} -> ISSUE.
  - ZPX: eff_addr={0,(byte+x_idx) mod 256} -> ISSUE. Never leaves page 0.
  - ABS, ABSX, ABSY, IND: -> OP_HI.
- OP_HI reads pc as the high byte hb; pc<=pc+1.
  - ABS: eff_addr={hb,oper} -> ISSUE.
  - ABSX: eff_addr=({hb,oper}+x_idx) mod 2^ADDR_W -> ISSUE.
  - ABSY: same as ABSX using y_idx -> ISSUE.
  - IND: ptr={hb,oper} -> IND_LO.
- IND_LO reads ptr into eff_addr[7:0]. Next pointer:
  - IND_PAGE_BUG=1: ptr<={ptr[15:8],ptr[7:0]+1}.
  - IND_PAGE_BUG=0: ptr<=ptr+1.
- IND_HI reads ptr into eff_addr[15:8] -> ISSUE.
- ISSUE: exec_valid=1; ir, oper and eff_addr are stable until accept.
  - Accept = exec_valid && exec_ready. On accept, exec_valid falls next cycle -> FETCH.
  - If pc_load=1 at accept, pc<=pc_target and the next FETCH reads pc_target.
  - pc_load outside accept is ignored.
- pc arithmetic is modulo 2^ADDR_W; FFFF+1 = 0000. Sums are computed at width+1 and truncated.
- Latency with mem_ready=1 and exec_ready=1, FETCH to accept inclusive:
  - IMP 3 cycles.
  - IMM/ZP/ZPX 4 cycles.
  - ABS/ABSX/ABSY 5 cycles.
  - IND 7 cycles.
- First FETCH occurs 3 cycles after resetn rises.
- x_idx and y_idx are sampled on the same cycle the operand byte that uses them is captured.

Test Plan:
- Reset vector: memory FFFC=00, FFFD=C0, mem_ready=1, release reset -> VEC reads at FFFC then FFFD; first FETCH mem_addr=C000 on cycle 3.
- IMM/IMP stream: C000=A9 (mode 1), C001=42, C002=EA (mode 0) -> bundle {ir=A9, oper=42}, then {ir=EA}; pc=C003; accepts 4 cycles apart from FETCH, then 3.
- ZPX wrap: operand F0, x_idx=20 -> eff_addr=0010. ABSX carry: operand FFF0, x_idx=20 -> eff_addr=0010 and pc advances by 3.
- IND page bug: ptr=10FF with 10FF=34, 1000=12, 1100=56. IND_PAGE_BUG=1 -> eff_addr=1234; IND_PAGE_BUG=0 -> eff_addr=5634.
- Stalls: mem_ready low 3 cycles during OP_HI, exec_ready low 2 cycles in ISSUE -> mem_addr and mem_rd held, bundle stable, no pc change. pc_load=1 with target 8000 on accept -> next FETCH at 8000.
- Mid-operation reset: resetn low during IND_LO -> next cycle all outputs at reset values; sequence restarts at VEC_LO. pc wrap: FETCH at FFFF -> pc=0000.
